// File: rtl/io_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_entry_ctrl : operator key/switch entry controller for the memory tester |
// | Pages address/data nibbles in from switches and issues one memory request. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module io_entry_ctrl #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int NSW     = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_mode_i,
    input  logic                key_step_i,
    input  logic [NSW-1:0]      sw_i,
    input  logic                mem_done_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                io_req_o,
    output logic [1:0]          io_op_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [1:0]          mode_o,
    output logic [3:0]          stage_o,
    output logic [4*NSW-1:0]    disp_data_o,
    output logic                io_done_o,
    output logic                err_o
);

    localparam int PW    = 4 * NSW;
    localparam int AP    = (ADDR_W + PW - 1) / PW;
    localparam int DP    = (DATA_W + PW - 1) / PW;
    localparam int AN    = (ADDR_W + 3) / 4;
    localparam int DN    = (DATA_W + 3) / 4;
    localparam int APW   = AP * PW;
    localparam int DPW   = DP * PW;
    localparam int CW    = $clog2(TIMEOUT);
    localparam int SYN_W = NSW + 2;

    localparam logic [1:0]    MODE_CLEAR  = 2'b00;
    localparam logic [1:0]    MODE_READ   = 2'b01;
    localparam logic [1:0]    MODE_WRITE  = 2'b10;
    localparam logic [3:0]    LAST_APG    = 4'(AP - 1);
    localparam logic [3:0]    LAST_DPG    = 4'(DP - 1);
    localparam logic [3:0]    DATA_STAGE0 = 4'(AP + 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUSY = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        page_q, page_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PW-1:0]     disp_q, disp_d;
    logic              io_req_q, io_done_q, io_done_d, err_q, err_d;

    logic [SYN_W-1:0]  sync1_q, sync2_q, sync3_q, rise;
    logic              mode_rise, step_rise;
    logic [NSW-1:0]    sw_rise;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            MODE_CLEAR: return MODE_WRITE;
            MODE_WRITE: return MODE_READ;
            default:    return MODE_CLEAR;
        endcase
    endfunction

    // Two flops resynchronise the pins; the third holds last cycle's value for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= {key_mode_i, key_step_i, sw_i};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise      = sync2_q & ~sync3_q;
    assign mode_rise = rise[SYN_W-1];
    assign step_rise = rise[NSW];
    assign sw_rise   = rise[NSW-1:0];

    // Each nibble wraps at its own width, so a partial top nibble rolls over early.
    for (genvar n = 0; n < AN; n++) begin : g_anib
        localparam int         LO = 4 * n;
        localparam int         NW = (ADDR_W - LO > 4) ? 4 : (ADDR_W - LO);
        localparam logic [3:0] PG = 4'(n / NSW);
        logic hit;
        assign hit = (state_q == S_ADDR) && (page_q == PG) && sw_rise[n % NSW];
        assign addr_d[LO +: NW] = addr_q[LO +: NW] + NW'(hit);
    end

    for (genvar n = 0; n < DN; n++) begin : g_dnib
        localparam int         LO = 4 * n;
        localparam int         NW = (DATA_W - LO > 4) ? 4 : (DATA_W - LO);
        localparam logic [3:0] PG = 4'(n / NSW);
        logic hit;
        assign hit = (state_q == S_DATA) && (page_q == PG) && sw_rise[n % NSW];
        assign data_d[LO +: NW] = data_q[LO +: NW] + NW'(hit);
    end

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        io_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode_rise) begin
                    mode_d = next_mode(mode_q);
                end else if (step_rise) begin
                    err_d   = 1'b0;
                    page_d  = 4'd0;
                    cnt_d   = '0;
                    state_d = (mode_q == MODE_CLEAR) ? S_BUSY : S_ADDR;
                end
            end
            S_ADDR: begin
                if (mode_rise) begin
                    state_d = S_IDLE;
                end else if (step_rise) begin
                    if (page_q == LAST_APG) begin
                        page_d  = 4'd0;
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_WRITE) ? S_DATA : S_BUSY;
                    end else begin
                        page_d = page_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (mode_rise) begin
                    state_d = S_IDLE;
                end else if (step_rise) begin
                    if (page_q == LAST_DPG) begin
                        page_d  = 4'd0;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        page_d = page_q + 4'd1;
                    end
                end
            end
            S_BUSY: begin
                if (mem_done_i) begin
                    io_done_d = 1'b1;
                    if (mode_q == MODE_READ) begin
                        rdata_d = mem_rdata_i;
                        state_d = S_SHOW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHOW: begin
                if (mode_rise) begin
                    mode_d  = next_mode(mode_q);
                    state_d = S_IDLE;
                end else if (step_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display follows the post-edge state so it changes on the same clock as the FSM.
    logic [APW-1:0] addr_pad;
    logic [DPW-1:0] data_pad;
    logic [PW-1:0]  addr_page, data_page;

    assign addr_pad = APW'(addr_d);
    assign data_pad = DPW'(data_d);

    always_comb begin
        addr_page = '0;
        data_page = '0;
        for (int k = 0; k < AP; k++) begin
            if (page_d == 4'(k)) addr_page = addr_pad[k*PW +: PW];
        end
        for (int k = 0; k < DP; k++) begin
            if (page_d == 4'(k)) data_page = data_pad[k*PW +: PW];
        end
        case (state_d)
            S_IDLE:  disp_d = '0;
            S_ADDR:  disp_d = addr_page;
            S_DATA:  disp_d = data_page;
            S_SHOW:  disp_d = PW'(rdata_d);
            default: disp_d = disp_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            page_q    <= 4'd0;
            mode_q    <= MODE_CLEAR;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            disp_q    <= '0;
            io_req_q  <= 1'b0;
            io_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            disp_q    <= disp_d;
            io_req_q  <= (state_d == S_BUSY);
            io_done_q <= io_done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        stage_o = 4'd0;
        case (state_q)
            S_ADDR:  stage_o = 4'd1 + page_q;
            S_DATA:  stage_o = DATA_STAGE0 + page_q;
            S_BUSY:  stage_o = 4'hE;
            S_SHOW:  stage_o = 4'hF;
            default: stage_o = 4'd0;
        endcase
    end

    assign io_req_o    = io_req_q;
    assign io_op_o     = mode_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;
    assign mode_o      = mode_q;
    assign disp_data_o = disp_q;
    assign io_done_o   = io_done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_io_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_io_entry_ctrl : directed self-checking bench for io_entry_ctrl          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_io_entry_ctrl;

    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 16;
    localparam int NSW     = 4;
    localparam int TIMEOUT = 1024;
    localparam int PW      = 4 * NSW;
    localparam int AP      = (ADDR_W + PW - 1) / PW;
    localparam int DP      = (DATA_W + PW - 1) / PW;
    localparam longint PMASK = (longint'(1) << PW) - 1;

    localparam int ST_IDLE = 0, ST_ADDR = 1, ST_DATA = 2, ST_BUSY = 3, ST_SHOW = 4;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              key_mode = 1'b0, key_step = 1'b0, mem_done = 1'b0;
    logic [NSW-1:0]    sw = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              io_req, io_done, err;
    logic [1:0]        io_op, mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        stage;
    logic [PW-1:0]     disp;

    int n_cmp = 0, n_bad = 0;

    io_entry_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSW(NSW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .key_mode_i(key_mode), .key_step_i(key_step), .sw_i(sw),
        .mem_done_i(mem_done), .mem_rdata_i(mem_rdata), .io_req_o(io_req), .io_op_o(io_op),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mode_o(mode), .stage_o(stage),
        .disp_data_o(disp), .io_done_o(io_done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                m_st = ST_IDLE, m_page = 0, m_cnt = 0, m_mode = 0;
    longint            m_addr = 0, m_data = 0, m_disp = 0, m_rdata = 0;
    bit                m_req = 0, m_done = 0, m_err = 0;
    logic [NSW+1:0]    hist [4];

    function automatic int mode_next(input int m);
        if (m == 0) return 2;
        if (m == 2) return 1;
        return 0;
    endfunction

    function automatic longint bump(input longint v, input int width, input int nib);
        int lo, nw;
        longint m, f;
        lo = 4 * nib;
        if (lo >= width) return v;
        nw = (width - lo < 4) ? (width - lo) : 4;
        m  = (longint'(1) << nw) - 1;
        f  = ((v >> lo) + 1) & m;
        return (v & ~(m << lo)) | (f << lo);
    endfunction

    function automatic int exp_stage();
        case (m_st)
            ST_ADDR: return 1 + m_page;
            ST_DATA: return 1 + AP + m_page;
            ST_BUSY: return 14;
            ST_SHOW: return 15;
            default: return 0;
        endcase
    endfunction

    task model_reset();
        m_st = ST_IDLE; m_page = 0; m_cnt = 0; m_mode = 0;
        m_addr = 0; m_data = 0; m_disp = 0; m_rdata = 0;
        m_req = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
    endtask

    // A pin rising before edge m-2 (low at edge m-3) takes effect at edge m.
    task model_step();
        logic [NSW+1:0] act;
        bit km, ks;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {key_mode, key_step, sw};
        act = hist[2] & ~hist[3];
        km  = act[NSW+1];
        ks  = act[NSW];
        m_done = 0;
        case (m_st)
            ST_IDLE: begin
                if (km) m_mode = mode_next(m_mode);
                else if (ks) begin
                    m_err = 0; m_page = 0; m_cnt = 0;
                    m_st = (m_mode == 0) ? ST_BUSY : ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                for (int i = 0; i < NSW; i++) begin
                    if (act[i]) begin
                        if (m_st == ST_ADDR) m_addr = bump(m_addr, ADDR_W, m_page * NSW + i);
                        else                 m_data = bump(m_data, DATA_W, m_page * NSW + i);
                    end
                end
                if (km) m_st = ST_IDLE;
                else if (ks) begin
                    if (m_st == ST_ADDR && m_page == AP - 1) begin
                        m_page = 0; m_cnt = 0;
                        m_st = (m_mode == 2) ? ST_DATA : ST_BUSY;
                    end else if (m_st == ST_DATA && m_page == DP - 1) begin
                        m_page = 0; m_cnt = 0; m_st = ST_BUSY;
                    end else m_page++;
                end
            end
            ST_BUSY: begin
                m_cnt++;
                if (mem_done) begin
                    m_done = 1;
                    if (m_mode == 1) begin m_rdata = longint'(mem_rdata); m_st = ST_SHOW; end
                    else m_st = ST_IDLE;
                end else if (m_cnt == TIMEOUT) begin
                    m_err = 1; m_st = ST_IDLE;
                end
            end
            default: begin
                if (km) begin m_mode = mode_next(m_mode); m_st = ST_IDLE; end
                else if (ks) m_st = ST_IDLE;
            end
        endcase
        m_req = (m_st == ST_BUSY);
        case (m_st)
            ST_IDLE: m_disp = 0;
            ST_ADDR: m_disp = (m_addr >> (PW * m_page)) & PMASK;
            ST_DATA: m_disp = (m_data >> (PW * m_page)) & PMASK;
            ST_SHOW: m_disp = m_rdata & PMASK;
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_io_req",  64'(io_req),    64'(m_req));
            check("m_io_done", 64'(io_done),   64'(m_done));
            check("m_err",     64'(err),       64'(m_err));
            check("m_mode",    64'(mode),      64'(m_mode));
            check("m_io_op",   64'(io_op),     64'(m_mode));
            check("m_stage",   64'(stage),     64'(exp_stage()));
            check("m_addr",    64'(mem_addr),  m_addr);
            check("m_wdata",   64'(mem_wdata), m_data);
            check("m_disp",    64'(disp),      m_disp);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        key_mode = 1'b1; tick(1); key_mode = 1'b0; tick(3);
    endtask

    task automatic press_step();
        key_step = 1'b1; tick(1); key_step = 1'b0; tick(3);
    endtask

    task automatic press_sw(input logic [NSW-1:0] mask, input int count);
        for (int i = 0; i < count; i++) begin
            sw = mask; tick(1); sw = '0; tick(1);
        end
        tick(3);
    endtask

    task automatic wait_req(input logic lvl, input int maxc);
        int c;
        c = 0;
        while (io_req !== lvl && c < maxc) begin tick(1); c++; end
        check("wait_io_req", 64'(io_req), 64'(lvl));
    endtask

    task automatic step_into_busy();
        key_step = 1'b1; tick(1); key_step = 1'b0;
        wait_req(1'b1, 10);
    endtask

    initial begin
        int hi, dn;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_stage", 64'(stage), 0);
        check("rst_mode",  64'(mode), 0);
        check("rst_req",   64'(io_req), 0);
        check("rst_disp",  64'(disp), 0);
        check("rst_addr",  64'(mem_addr), 0);
        check("rst_err",   64'(err), 0);

        press_mode(); press_mode();
        check("mode_x2", 64'(mode), 64'h1);
        // Third press: no change after two edges, change on the third
        key_mode = 1'b1; tick(1); key_mode = 1'b0;
        check("lat_e1", 64'(mode), 64'h1);
        tick(1);
        check("lat_e2", 64'(mode), 64'h1);
        tick(1);
        check("lat_e3", 64'(mode), 64'h0);
        tick(1);

        // WRITE operation
        press_mode();
        check("mode_write", 64'(mode), 64'h2);
        press_step();
        check("wr_stage_a0", 64'(stage), 1);
        press_sw(4'b0001, 3);
        press_sw(4'b1000, 1);
        check("wr_disp_a0", 64'(disp), 64'h1003);
        press_step();
        check("wr_stage_a1", 64'(stage), 2);
        press_sw(4'b0100, 1);
        press_step();
        check("wr_stage_d0", 64'(stage), 3);
        press_sw(4'b0010, 2);
        check("wr_disp_d0", 64'(disp), 64'h0020);
        step_into_busy();
        check("wr_addr",  64'(mem_addr), 64'h1001003);
        check("wr_wdata", 64'(mem_wdata), 64'h0020);
        check("wr_op",    64'(io_op), 64'h2);
        check("wr_stage_busy", 64'(stage), 64'hE);
        tick(4);
        mem_done = 1'b1; tick(1); mem_done = 1'b0;
        check("wr_done", 64'(io_done), 1);
        check("wr_req_low", 64'(io_req), 0);
        tick(1);
        check("wr_done_pulse", 64'(io_done), 0);
        check("wr_idle", 64'(stage), 0);

        // READ operation at 0x0000010
        press_mode();
        press_step();
        press_sw(4'b1001, 13);
        press_sw(4'b1000, 2);
        press_sw(4'b0010, 1);
        check("rd_disp_a0", 64'(disp), 64'h0010);
        press_step();
        press_sw(4'b0100, 1);
        step_into_busy();
        check("rd_addr", 64'(mem_addr), 64'h10);
        check("rd_op",   64'(io_op), 64'h1);
        tick(2);
        mem_rdata = 16'hBEEF; mem_done = 1'b1; tick(1); mem_done = 1'b0; mem_rdata = '0;
        check("rd_stage_show", 64'(stage), 64'hF);
        check("rd_disp", 64'(disp), 64'hBEEF);
        check("rd_done", 64'(io_done), 1);
        press_step();
        check("rd_back_idle", 64'(stage), 0);
        check("rd_mode_kept", 64'(mode), 64'h1);

        // Wrap from a fresh reset, then simultaneous abort
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        press_mode();
        press_step();
        press_sw(4'b0001, 17);
        check("wrap_nib0", 64'(disp), 64'h0001);
        press_step();
        press_sw(4'b0100, 1);
        check("wrap_top1", 64'(disp), 64'h0100);
        press_sw(4'b0100, 1);
        check("wrap_top0", 64'(mem_addr), 64'h1);
        key_mode = 1'b1; key_step = 1'b1; tick(1); key_mode = 1'b0; key_step = 1'b0; tick(3);
        check("sim_idle", 64'(stage), 0);
        check("sim_mode", 64'(mode), 64'h2);
        check("sim_addr", 64'(mem_addr), 64'h1);

        // CLEAR with no completion: timeout
        press_mode(); press_mode();
        check("clr_mode", 64'(mode), 0);
        step_into_busy();
        hi = 0; dn = 0;
        while (io_req === 1'b1 && hi < 2000) begin
            hi++;
            if (io_done === 1'b1) dn++;
            tick(1);
        end
        check("to_req_cycles", 64'(hi), 64'(TIMEOUT));
        check("to_done_none", 64'(dn), 0);
        check("to_done_end", 64'(io_done), 0);
        check("to_err", 64'(err), 1);
        check("to_idle", 64'(stage), 0);

        // Next accepted step clears err; then async reset mid-BUSY
        step_into_busy();
        check("err_cleared", 64'(err), 0);
        #2 rst_n = 1'b0;
        #1 check("async_req", 64'(io_req), 0);
        check("async_stage", 64'(stage), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_mode", 64'(mode), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
